// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : ALU op codes, sequencer state encoding and op classifiers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [4:0] c_op_add = 5'b00011;
    localparam logic [4:0] c_op_sub = 5'b00100;
    localparam logic [4:0] c_op_neg = 5'b00101;
    localparam logic [4:0] c_op_not = 5'b00110;
    localparam logic [4:0] c_op_and = 5'b00111;
    localparam logic [4:0] c_op_or  = 5'b01000;
    localparam logic [4:0] c_op_mul = 5'b01001;
    localparam logic [4:0] c_op_div = 5'b01010;

    localparam int         c_st_w       = 3;
    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_load_y  = 3'd1;
    localparam logic [2:0] c_st_exec    = 3'd2;
    localparam logic [2:0] c_st_wb_lo   = 3'd3;
    localparam logic [2:0] c_st_wb_hi   = 3'd4;
    localparam logic [2:0] c_st_done    = 3'd5;
    localparam logic [2:0] c_st_err     = 3'd6;

    function automatic logic is_legal(input logic [4:0] op);
        return (op >= c_op_add) && (op <= c_op_div);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == c_op_neg) || (op == c_op_not);
    endfunction

    function automatic logic is_wide(input logic [4:0] op);
        return (op == c_op_mul) || (op == c_op_div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : reg_onehot_dec
// Description : Register index plus enable to one-hot strobe vector.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_onehot_dec #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       i_idx,
    input  logic             i_en,
    output logic [NREGS-1:0] o_onehot
);

    // Index wraps modulo the register count so a short file never sees an out-of-range strobe.
    logic [31:0] w_idx_mod;
    assign w_idx_mod = {28'd0, i_idx} % 32'(NREGS);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
        assign o_onehot[gi] = i_en & (w_idx_mod == 32'(gi));
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Moore control-step sequencer driving data_path strobes for one ALU op.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [OPW-1:0]   op_in,
    input  logic [3:0]       rd,
    input  logic [3:0]       rs1,
    input  logic [3:0]       rs2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [OPW-1:0]   op,
    output logic [NREGS-1:0] Rout,
    output logic [NREGS-1:0] Rin,
    output logic             Yin,
    output logic             ZHighin,
    output logic             Zlowin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             LOin
);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_next;
    logic [OPW-1:0]    r_op;
    logic [3:0]        r_rd;
    logic [3:0]        r_rs1;
    logic [3:0]        r_rs2;

    logic       w_req_legal;
    logic       w_rout_en;
    logic [3:0] w_rout_idx;
    logic       w_rin_en;

    assign w_req_legal = is_legal(5'(op_in));

    always_ff @(posedge Clock) begin
        if (!clear) begin
            r_state <= c_st_idle;
            r_op    <= '0;
            r_rd    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_st_idle) && start && w_req_legal) begin
                r_op  <= op_in;
                r_rd  <= rd;
                r_rs1 <= rs1;
                r_rs2 <= rs2;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        op         = '0;
        Yin        = 1'b0;
        ZHighin    = 1'b0;
        Zlowin     = 1'b0;
        Zhighout   = 1'b0;
        Zlowout    = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        w_rout_en  = 1'b0;
        w_rout_idx = r_rs1;
        w_rin_en   = 1'b0;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (start) begin
                    if (!w_req_legal)               w_next = c_st_err;
                    else if (is_unary(5'(op_in)))   w_next = c_st_exec;
                    else                            w_next = c_st_load_y;
                end
            end
            c_st_load_y: begin
                w_rout_en = 1'b1;
                Yin       = 1'b1;
                w_next    = c_st_exec;
            end
            c_st_exec: begin
                op         = r_op;
                w_rout_en  = 1'b1;
                w_rout_idx = is_unary(5'(r_op)) ? r_rs1 : r_rs2;
                ZHighin    = 1'b1;
                Zlowin     = 1'b1;
                w_next     = c_st_wb_lo;
            end
            c_st_wb_lo: begin
                Zlowout = 1'b1;
                if (is_wide(5'(r_op))) begin
                    LOin   = 1'b1;
                    w_next = c_st_wb_hi;
                end else begin
                    w_rin_en = 1'b1;
                    w_next   = c_st_done;
                end
            end
            c_st_wb_hi: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                w_next   = c_st_done;
            end
            c_st_done: begin
                done   = 1'b1;
                w_next = c_st_idle;
            end
            c_st_err: begin
                err    = 1'b1;
                w_next = c_st_idle;
            end
            default: begin
                busy   = 1'b0;
                w_next = c_st_idle;
            end
        endcase
    end

    reg_onehot_dec #(.NREGS(NREGS)) u_rout_dec (
        .i_idx    (w_rout_idx),
        .i_en     (w_rout_en),
        .o_onehot (Rout)
    );

    reg_onehot_dec #(.NREGS(NREGS)) u_rin_dec (
        .i_idx    (r_rd),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed bench with a behavioural data_path model around the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic        Clock = 1'b0;
    logic        clear;
    logic        start;
    logic [4:0]  op_in;
    logic [3:0]  rd, rs1, rs2;
    logic        busy, done, err;
    logic [4:0]  op;
    logic [15:0] Rout, Rin;
    logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin;

    int n_assert = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.NREGS(16), .OPW(5)) dut (
        .Clock(Clock), .clear(clear), .start(start), .op_in(op_in),
        .rd(rd), .rs1(rs1), .rs2(rs2),
        .busy(busy), .done(done), .err(err), .op(op),
        .Rout(Rout), .Rin(Rin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin)
    );

    always #5 Clock = ~Clock;

    // Behavioural data_path: register file, Y, 64-bit Z, HI/LO and one shared bus.
    logic [31:0] regs [16];
    logic [31:0] y_reg, hi_reg, lo_reg, bus;
    logic [63:0] z_reg, alu;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always_comb begin
        bus = '0;
        for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | regs[i];
        if (Zlowout)  bus = bus | z_reg[31:0];
        if (Zhighout) bus = bus | z_reg[63:32];
    end

    always_comb begin
        alu = '0;
        case (op)
            5'b00011: alu = {32'd0, y_reg + bus};
            5'b00100: alu = {32'd0, y_reg - bus};
            5'b00101: alu = {32'd0, -bus};
            5'b00110: alu = {32'd0, ~bus};
            5'b00111: alu = {32'd0, y_reg & bus};
            5'b01000: alu = {32'd0, y_reg | bus};
            5'b01001: alu = {32'd0, y_reg} * {32'd0, bus};
            5'b01010: alu = (bus == 0) ? 64'd0 : {y_reg % bus, y_reg / bus};
            default:  alu = '0;
        endcase
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = '0;
        y_reg = '0; z_reg = '0; hi_reg = '0; lo_reg = '0;
    end

    always @(posedge Clock) begin
        if (Yin) y_reg <= bus;
        if (Zlowin || ZHighin) z_reg <= alu;
        if (HIin) hi_reg <= bus;
        if (LOin) lo_reg <= bus;
        for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus;
        if (pl_en) regs[pl_idx] <= pl_val;
    end

    // Event counters over the cycle that ends at each rising edge.
    int busy_cnt = 0, done_cnt = 0, err_cnt = 0, rin_cnt = 0, hilo_cnt = 0;
    int yin_cnt = 0, op_cyc = 0, strobe_cnt = 0, conflict_cnt = 0;
    logic [4:0] last_op = '0;

    always @(posedge Clock) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (err)  err_cnt++;
        rin_cnt += $countones(Rin);
        if (HIin || LOin) hilo_cnt++;
        if (Yin) yin_cnt++;
        if (op != 0) begin op_cyc++; last_op = op; end
        if (|{Rout, Rin, Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin}) strobe_cnt++;
        if (($countones(Rout) + int'(Zlowout) + int'(Zhighout)) > 1 || $countones(Rin) > 1)
            conflict_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] all_outs();
        return {busy, done, err, op, Rout, Rin, Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, LOin};
    endfunction

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(negedge Clock);
        pl_en = 1'b0;
    endtask

    // Drives a one-cycle start; returns at the negedge of the first cycle after sampling.
    task automatic issue(input logic [4:0] o, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
        start = 1'b1; op_in = o; rd = d; rs1 = s1; rs2 = s2;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic wait_end(input int n_from, output int lat);
        int n = n_from;
        lat = 99;
        while (n <= 20) begin
            if (done || err) begin lat = n; break; end
            @(negedge Clock);
            n++;
        end
        @(negedge Clock);
    endtask

    int lat;
    int s_done, s_rin, s_hilo, s_yin, s_op, s_busy, s_err, s_strobe;

    task automatic snap();
        s_done = done_cnt; s_rin = rin_cnt; s_hilo = hilo_cnt; s_yin = yin_cnt;
        s_op = op_cyc; s_busy = busy_cnt; s_err = err_cnt; s_strobe = strobe_cnt;
    endtask

    initial begin
        clear = 1'b0; start = 1'b0; op_in = '0; rd = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge Clock);
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        clear = 1'b1;
        preload(4'd3, 32'd12);
        preload(4'd4, 32'd5);

        // Reset during EXEC must abort with no writeback.
        snap();
        issue(5'b00011, 4'd1, 4'd3, 4'd4);
        chk("midop_loady_rout", 64'(Rout), 64'h0008);
        chk("midop_loady_yin", 64'(Yin), 64'd1);
        @(negedge Clock);
        chk("midop_exec_op", 64'(op), 64'h03);
        clear = 1'b0;
        @(negedge Clock);
        chk("midop_reset_outputs", 64'(all_outs()), 64'd0);
        clear = 1'b1;
        repeat (2) @(negedge Clock);
        chk("midop_idle_outputs", 64'(all_outs()), 64'd0);
        chk("midop_no_rin", 64'(rin_cnt - s_rin), 64'd0);
        chk("midop_r1_untouched", 64'(regs[1]), 64'd0);

        // ADD R1 = R3 + R4
        snap();
        issue(5'b00011, 4'd1, 4'd3, 4'd4);
        wait_end(1, lat);
        chk("add_latency", 64'(lat), 64'd4);
        chk("add_r1", 64'(regs[1]), 64'd17);
        chk("add_y", 64'(y_reg), 64'd12);
        chk("add_no_hilo", 64'(hilo_cnt - s_hilo), 64'd0);
        chk("add_done_once", 64'(done_cnt - s_done), 64'd1);
        chk("add_idle_busy", 64'(busy), 64'd0);

        // NEG R1 = -R2
        preload(4'd2, 32'd5);
        snap();
        issue(5'b00101, 4'd1, 4'd2, 4'd0);
        wait_end(1, lat);
        chk("neg_latency", 64'(lat), 64'd3);
        chk("neg_r1", 64'(regs[1]), 64'hFFFF_FFFB);
        chk("neg_no_yin", 64'(yin_cnt - s_yin), 64'd0);
        chk("neg_op_cycles", 64'(op_cyc - s_op), 64'd1);
        chk("neg_op_value", 64'(last_op), 64'h05);

        // MUL HI:LO = R2 * R3
        preload(4'd2, 32'h0001_0000);
        preload(4'd3, 32'h0001_0000);
        snap();
        issue(5'b01001, 4'd9, 4'd2, 4'd3);
        wait_end(1, lat);
        chk("mul_latency", 64'(lat), 64'd5);
        chk("mul_lo", 64'(lo_reg), 64'd0);
        chk("mul_hi", 64'(hi_reg), 64'd1);
        chk("mul_no_rin", 64'(rin_cnt - s_rin), 64'd0);
        chk("mul_hilo_cycles", 64'(hilo_cnt - s_hilo), 64'd2);

        // ADD R6 = R3 + R4 with a competing start while busy
        snap();
        issue(5'b00011, 4'd6, 4'd3, 4'd4);
        start = 1'b1; op_in = 5'b00100; rd = 4'd7; rs1 = 4'd4; rs2 = 4'd3;
        @(negedge Clock);
        start = 1'b0;
        wait_end(2, lat);
        repeat (4) @(negedge Clock);
        chk("busy_latency", 64'(lat), 64'd4);
        chk("busy_r6", 64'(regs[6]), 64'h0001_0005);
        chk("busy_r7_untouched", 64'(regs[7]), 64'd0);
        chk("busy_rin_once", 64'(rin_cnt - s_rin), 64'd1);
        chk("busy_done_once", 64'(done_cnt - s_done), 64'd1);

        // Illegal op
        snap();
        issue(5'b11111, 4'd1, 4'd2, 4'd3);
        chk("err_pulse", 64'(err), 64'd1);
        chk("err_busy", 64'(busy), 64'd1);
        @(negedge Clock);
        chk("err_cleared", 64'({err, busy}), 64'd0);
        repeat (3) @(negedge Clock);
        chk("err_busy_cycles", 64'(busy_cnt - s_busy), 64'd1);
        chk("err_count", 64'(err_cnt - s_err), 64'd1);
        chk("err_no_strobes", 64'(strobe_cnt - s_strobe), 64'd0);
        chk("err_no_done", 64'(done_cnt - s_done), 64'd0);
        chk("err_r1_kept", 64'(regs[1]), 64'hFFFF_FFFB);

        chk("single_bus_source", 64'(conflict_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Synthesizable control-step sequencer for `data_path`. It drives the register-transfer micro-operation sequence that the bench currently hand-codes.
- It accepts one register-register (or unary) ALU request and drives the datapath's out/in strobes and `op` code one state per clock: operand to Y, execute into Z, write back Zlow (and Zhigh for wide results).
- It sits between instruction decode and `data_path`, and owns every bus-source and register-load enable it touches.

Parameters:
- NREGS, 16, number of general registers; width of the one-hot register strobe vectors.
- OPW, 5, width of the ALU op code.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- op_in  in  OPW  requested ALU op.
- rd  in  4  destination register index (ignored for MUL/DIV).
- rs1  in  4  first source register index.
- rs2  in  4  second source register index (ignored for unary ops).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion.
- err  out  1  one-cycle pulse when an illegal op is rejected.
- op  out  OPW  ALU op presented to `data_path`; 0 outside EXEC.
- Rout  out  NREGS  one-hot register bus-drive enables (R0out..R15out).
- Rin  out  NREGS  one-hot register load enables (R0in..R15in).
- Yin, ZHighin, Zlowin  out  1 each  Y and Z load enables.
- Zhighout, Zlowout  out  1 each  Z bus-drive enables.
- HIin, LOin  out  1 each  HI/LO load enables.

Behaviour:
- Outputs are Moore, decoded from the registered state and the latched request fields only. None depend combinationally on `start` or `op_in`.
- At most one bus source is active in any cycle.
- Reset: on a rising edge with clear=0, state goes to IDLE and the request registers are zeroed. Every output is 0 from the next cycle. This includes reset mid-operation: no partial writeback completes after the reset edge.
- IDLE:
  - On start=1 with a legal op, latch op_in, rd, rs1, rs2.
  - Next state is LOAD_Y for binary ops; unary ops (NEG, NOT) skip straight to EXEC.
  - On start=1 with an illegal op, go to ERR. Nothing is latched and no datapath strobe fires.
- LOAD_Y: Rout[rs1]=1, Yin=1 → EXEC.
- EXEC:
  - op=latched op.
  - Binary ops: Rout[rs2]=1. Unary ops: Rout[rs1]=1.
  - ZHighin=1, Zlowin=1.
  - → WB_LO.
- WB_LO: Zlowout=1. For MUL/DIV, LOin=1 → WB_HI. Otherwise Rin[rd]=1 → DONE.
- WB_HI: Zhighout=1, HIin=1 → DONE.
- DONE: done=1 → IDLE.
- ERR: err=1 → IDLE.
- Latency from the start-sampling edge to the done pulse:
  - Binary non-wide ops: 4 cycles (LOAD_Y, EXEC, WB_LO, DONE).
  - Unary ops: 3 cycles.
  - MUL/DIV: 5 cycles.
- The next request can be accepted on the edge after DONE, i.e. throughput is one op per latency+1 cycles.
- start while busy: ignored and not queued. The requester must hold or re-issue it.
- Register aliasing (rd==rs1, rd==rs2, rs1==rs2) needs no special handling, because the transfers are sequential.
- Rout/Rin one-hot encoding: exactly one bit set when active, all-zero otherwise. Index is taken modulo NREGS.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - Op codes: ADD=5'b00011, SUB=5'b00100, NEG=5'b00101, NOT=5'b00110, AND=5'b00111, OR=5'b01000, MUL=5'b01001, DIV=5'b01010. Every other value is illegal.
  - State encoding enum.
  - Helper classifications: is_unary, is_wide.
- One sub-module is natural: `reg_onehot_dec` (4-bit index + enable → NREGS one-hot), instantiated twice, once for Rout and once for Rin.

Test Plan:
- Reset mid-op: assert clear=0 during EXEC → next cycle all outputs 0, busy=0; a start afterwards (with clear=1) runs normally.
- ADD, rs1=3, rs2=4, rd=1, with R3=12 and R4=5 preloaded → Y loaded from R3, op=ADD in EXEC, R1=17, done 4 cycles after start, no HIin/LOin.
- NEG, rs1=2, rd=1, with R2=5 → LOAD_Y skipped, op=5'b00101 for one cycle, R1=32'hFFFFFFFB, done after 3 cycles.
- MUL, rs1=2, rs2=3, with R2=32'h00010000 and R3=32'h00010000 → LO=0, HI=1, no Rin bit ever set, done after 5 cycles.
- start re-pulsed while busy during an ADD, with different fields → ignored; original rd written once, done pulses exactly once.
- op_in=5'b11111 → err pulses 1 cycle after start; no strobes, no done, busy high for exactly one cycle.
